// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS_32 core: datapath widths, control-bit
// positions inside the 7-bit decoded control word, and ALU op encodings.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 7;
    localparam int SHAMT_W    = 5;

    localparam int CTRL_REG_WRITE = 6;
    localparam int CTRL_MEM_READ  = 5;
    localparam int CTRL_MEM_WRITE = 4;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC   = 2;
    localparam int CTRL_REG_DST   = 1;
    localparam int CTRL_BRANCH    = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 7'b0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_NOR = 4'h5,
        ALU_SLT = 4'h6,
        ALU_SLL = 4'h7,
        ALU_SRL = 4'h8,
        ALU_SRA = 4'h9,
        ALU_LUI = 4'hA
    } alu_op_e;

endpackage

// File: rtl/wb_bypass_mux.sv
// Selects the write-back result over the register-file read data when the
// WB stage is writing the very register this operand reads (never $zero).
module wb_bypass_mux #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic [DATA_W-1:0]     rf_data,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     op_data
);
    import mips_pkg::*;

    logic hit;

    always_comb begin
        hit     = wb_we && (wb_addr != '0) && (wb_addr == src_addr);
        op_data = hit ? wb_data : rf_data;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures ID operands, immediate and decoded control
// for EX, with stall/flush handling, WB bypass on capture and a bubble counter.
module id_ex_reg #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int ALU_OP_W   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [4:0]            id_shamt,
    input  logic [6:0]            id_ctrl,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [4:0]            ex_shamt,
    output logic [6:0]            ex_ctrl,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [CNT_W-1:0]      bubble_cnt
);
    import mips_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs_byp (
        .rf_data (id_rs_data),
        .src_addr(id_rs),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .op_data (rs_fwd)
    );

    wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rt_byp (
        .rf_data (id_rt_data),
        .src_addr(id_rt),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .op_data (rt_fwd)
    );

    logic                  valid_d, valid_q;
    logic [DATA_W-1:0]     pc_d, pc_q, rs_data_d, rs_data_q, rt_data_d, rt_data_q;
    logic [DATA_W-1:0]     imm_d, imm_q;
    logic [REG_ADDR_W-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [4:0]            shamt_d, shamt_q;
    logic [6:0]            ctrl_d, ctrl_q;
    logic [ALU_OP_W-1:0]   alu_op_d, alu_op_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        shamt_d   = shamt_q;
        ctrl_d    = ctrl_q;
        alu_op_d  = alu_op_q;
        cnt_d     = cnt_q;
        if (flush) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            shamt_d   = '0;
            ctrl_d    = CTRL_NOP;
            alu_op_d  = '0;
            cnt_d     = sat_inc(cnt_q);
        end else if (!stall) begin
            // An invalid ID slot still carries its data, but must not act in EX.
            valid_d   = id_valid;
            pc_d      = id_pc;
            rs_data_d = rs_fwd;
            rt_data_d = rt_fwd;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            shamt_d   = id_shamt;
            ctrl_d    = id_valid ? id_ctrl : CTRL_NOP;
            alu_op_d  = id_valid ? id_alu_op : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            ctrl_q    <= '0;
            alu_op_q  <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            shamt_q   <= shamt_d;
            ctrl_q    <= ctrl_d;
            alu_op_q  <= alu_op_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_shamt   = shamt_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_alu_op  = alu_op_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Table-driven bench for id_ex_reg: each vector's expected EX state is queued
// when the vector is driven and compared one clock edge later.
module tb_id_ex_reg;

    typedef struct packed {
        logic        rst, stall, flush, valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, wb_we;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm, wb_data;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, wb_addr;
    logic [6:0]  id_ctrl;
    logic [3:0]  id_alu_op;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [6:0]  ex_ctrl;
    logic [3:0]  ex_alu_op;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;
    out_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALU_OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; flush = v.flush; id_valid = v.valid;
        id_pc = v.pc; id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_shamt = v.shamt;
        id_ctrl = v.ctrl; id_alu_op = v.alu;
        wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
    endtask

    task automatic step(input in_t v, input out_t e, input int idx);
        out_t x;
        drive(v);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard step %0d: queue empty", idx);
        end else begin
            x = sb_q.pop_front();
            chk("ex_valid",   idx, 32'(ex_valid),   32'(x.valid));
            chk("ex_pc",      idx, ex_pc,           x.pc);
            chk("ex_rs_data", idx, ex_rs_data,      x.rs_data);
            chk("ex_rt_data", idx, ex_rt_data,      x.rt_data);
            chk("ex_imm",     idx, ex_imm,          x.imm);
            chk("ex_rs",      idx, 32'(ex_rs),      32'(x.rs));
            chk("ex_rt",      idx, 32'(ex_rt),      32'(x.rt));
            chk("ex_rd",      idx, 32'(ex_rd),      32'(x.rd));
            chk("ex_shamt",   idx, 32'(ex_shamt),   32'(x.shamt));
            chk("ex_ctrl",    idx, 32'(ex_ctrl),    32'(x.ctrl));
            chk("ex_alu_op",  idx, 32'(ex_alu_op),  32'(x.alu));
            chk("bubble_cnt", idx, 32'(bubble_cnt), 32'(x.cnt));
        end
    endtask

    initial begin
        in_t  in_rst, in_ld, in_st, in_fl;
        out_t e_ld, e_zero, e_tmp;

        e_zero = '0;
        in_rst = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hAA, 32'hBB, 32'hCC,
                   5'd7, 5'd8, 5'd9, 5'd10, 7'h7F, 4'hF, 1'b1, 5'd7, 32'h99};
        in_ld  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400004, 32'h11, 32'h22, 32'hFFFF8000,
                   5'd1, 5'd2, 5'd3, 5'd4, 7'b1000100, 4'h2, 1'b0, 5'd0, 32'h0};
        e_ld   = '{1'b1, 32'h00400004, 32'h11, 32'h22, 32'hFFFF8000,
                   5'd1, 5'd2, 5'd3, 5'd4, 7'b1000100, 4'h2, 16'd0};
        // Changed inputs with a live WB hit on rs: nothing may leak through a stall.
        in_st  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00001000, 32'h33, 32'h44, 32'h5,
                   5'd1, 5'd2, 5'd6, 5'd0, 7'b0000001, 4'h7, 1'b1, 5'd1, 32'hBAD0BAD0};
        in_fl  = in_st;
        in_fl.flush = 1'b1;

        tbl.push_back('{in_rst, e_zero});
        tbl.push_back('{in_rst, e_zero});
        tbl.push_back('{in_ld, e_ld});
        tbl.push_back('{in_st, e_ld});
        tbl.push_back('{in_st, e_ld});
        tbl.push_back('{in_st, e_ld});
        e_tmp = e_zero; e_tmp.cnt = 16'd1;
        tbl.push_back('{in_fl, e_tmp});
        tbl.push_back('{'{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400008, 32'h55, 32'h66, 32'h10,
                          5'd5, 5'd5, 5'd4, 5'd0, 7'b0100110, 4'h1, 1'b1, 5'd5, 32'hDEADBEEF},
                        '{1'b1, 32'h00400008, 32'hDEADBEEF, 32'hDEADBEEF, 32'h10,
                          5'd5, 5'd5, 5'd4, 5'd0, 7'b0100110, 4'h1, 16'd1}});
        tbl.push_back('{'{1'b0, 1'b0, 1'b0, 1'b1, 32'h0040000C, 32'h77, 32'h88, 32'h0,
                          5'd0, 5'd0, 5'd2, 5'd3, 7'b1000001, 4'h3, 1'b1, 5'd0, 32'hDEADBEEF},
                        '{1'b1, 32'h0040000C, 32'h77, 32'h88, 32'h0,
                          5'd0, 5'd0, 5'd2, 5'd3, 7'b1000001, 4'h3, 16'd1}});
        tbl.push_back('{'{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400010, 32'h101, 32'h202, 32'hFFFFFFFF,
                          5'd3, 5'd9, 5'd10, 5'd31, 7'b1010000, 4'h4, 1'b1, 5'd9, 32'hCAFEF00D},
                        '{1'b1, 32'h00400010, 32'h101, 32'hCAFEF00D, 32'hFFFFFFFF,
                          5'd3, 5'd9, 5'd10, 5'd31, 7'b1010000, 4'h4, 16'd1}});
        tbl.push_back('{'{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400014, 32'h303, 32'h404, 32'h7FFF,
                          5'd9, 5'd9, 5'd1, 5'd1, 7'b1000000, 4'h5, 1'b0, 5'd9, 32'h12121212},
                        '{1'b1, 32'h00400014, 32'h303, 32'h404, 32'h7FFF,
                          5'd9, 5'd9, 5'd1, 5'd1, 7'b1000000, 4'h5, 16'd1}});
        tbl.push_back('{'{1'b0, 1'b0, 1'b0, 1'b0, 32'h00400018, 32'h505, 32'h606, 32'h8,
                          5'd11, 5'd12, 5'd13, 5'd2, 7'h7F, 4'hF, 1'b0, 5'd0, 32'h0},
                        '{1'b0, 32'h00400018, 32'h505, 32'h606, 32'h8,
                          5'd11, 5'd12, 5'd13, 5'd2, 7'h00, 4'h0, 16'd1}});
        e_tmp = e_zero; e_tmp.cnt = 16'd2;
        tbl.push_back('{'{1'b0, 1'b0, 1'b1, 1'b1, 32'h0040001C, 32'h1, 32'h2, 32'h3,
                          5'd1, 5'd2, 5'd3, 5'd4, 7'h44, 4'h6, 1'b1, 5'd1, 32'hFFFF0000}, e_tmp});
        tbl.push_back('{'{1'b1, 1'b1, 1'b1, 1'b1, 32'h00400020, 32'h9, 32'h9, 32'h9,
                          5'd1, 5'd2, 5'd3, 5'd4, 7'h7F, 4'hF, 1'b1, 5'd1, 32'h9}, e_zero});

        foreach (tbl[k]) step(tbl[k].i, tbl[k].e, k);

        // Saturation: 0xFFFF+2 flushes in total; counter must pin at all-ones.
        in_fl.stall = 1'b0;
        for (int n = 0; n < 16'hFFFD; n++) drive(in_fl);
        e_tmp = e_zero; e_tmp.cnt = 16'hFFFE;
        step(in_fl, e_tmp, 100);
        e_tmp.cnt = 16'hFFFF;
        step(in_fl, e_tmp, 101);
        step(in_fl, e_tmp, 102);
        step(in_fl, e_tmp, 103);
        e_tmp = e_ld; e_tmp.cnt = 16'hFFFF;
        step(in_ld, e_tmp, 104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
